// File: rtl/mac_dispatch_pkg.sv
// Shared definitions for the MAC dispatch path: default operand geometry,
// the partial-sum width helper and the dispatcher state encoding.
package mac_dispatch_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int BLOCK_DEPTH_DEF = 32;
    localparam int PSUM_WIDTH_DEF  = 2*DATA_WIDTH_DEF + clog2(BLOCK_DEPTH_DEF*3);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_EMIT    = 3'd4
    } disp_state_t;

endpackage

// File: rtl/blk_fifo2.sv
// Two-entry block buffer. The count is registered, so a full/empty decision
// taken from it never has a combinational path back from pop_i.
module blk_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && (count_q != 2'd2);
    assign pop_ok  = pop_i  && (count_q != 2'd0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/mac_dispatch.sv
// Feeds operand blocks to a handshake-driven MAC and chains partial sums
// until a last block. Build option MAC_DISPATCH_ZSKIP_EN skips all-zero blocks.
//
// state      | meaning
// IDLE       | wait for a buffered block and an idle MAC
// ISSUE      | one-cycle mac_sta with head operands, pop head
// WAIT_LO    | wait for MAC to drop mac_fnh
// WAIT_HI    | wait for mac_fnh to rise, capture mac_psum
// EMIT       | hold finished sum on out_psum until out_ready
module mac_dispatch
    import mac_dispatch_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int BLOCK_DEPTH = BLOCK_DEPTH_DEF,
    parameter int PSUM_WIDTH  = 2*DATA_WIDTH + clog2(BLOCK_DEPTH*3)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [BLOCK_DEPTH-1:0]              in_flg_act,
    input  logic [DATA_WIDTH*BLOCK_DEPTH-1:0]   in_act,
    input  logic [BLOCK_DEPTH-1:0]              in_flg_wei,
    input  logic [DATA_WIDTH*BLOCK_DEPTH-1:0]   in_wei,
    input  logic                                in_last,
    output logic                                mac_sta,
    input  logic                                mac_fnh,
    output logic [BLOCK_DEPTH-1:0]              mac_flg_act,
    output logic [DATA_WIDTH*BLOCK_DEPTH-1:0]   mac_act,
    output logic [BLOCK_DEPTH-1:0]              mac_flg_wei,
    output logic [DATA_WIDTH*BLOCK_DEPTH-1:0]   mac_wei,
    output logic signed [PSUM_WIDTH-1:0]        mac_psum_init,
    input  logic signed [PSUM_WIDTH-1:0]        mac_psum,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [PSUM_WIDTH-1:0]        out_psum
);

    localparam int AW      = DATA_WIDTH*BLOCK_DEPTH;
    localparam int OPS_W   = 2*BLOCK_DEPTH + 2*AW;
    localparam int ENTRY_W = OPS_W + 1;

    disp_state_t                 state_q;
    logic signed [PSUM_WIDTH-1:0] acc_q;
    logic signed [PSUM_WIDTH-1:0] init_q;
    logic signed [PSUM_WIDTH-1:0] out_psum_q;
    logic                        first_q;
    logic                        last_q;
    logic                        sta_q;
    logic                        out_valid_q;
    logic [OPS_W-1:0]            ops_q;

    logic [ENTRY_W-1:0]          head;
    logic [1:0]                  count;
    logic                        push;
    logic                        pop;
    logic                        h_last;
    logic                        skip;

    assign in_ready = ~count[1];
    assign push     = in_valid & in_ready;
    assign pop      = (state_q == ST_ISSUE);
    assign h_last   = head[ENTRY_W-1];

    // Entry layout: {last, flg_act, act, flg_wei, wei}, matching the mac_* bus order.
    blk_fifo2 #(.WIDTH(ENTRY_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  ({in_last, in_flg_act, in_act, in_flg_wei, in_wei}),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
    );

`ifdef MAC_DISPATCH_ZSKIP_EN
    assign skip = ~|(head[ENTRY_W-2 -: BLOCK_DEPTH] & head[AW +: BLOCK_DEPTH]);
`else
    assign skip = 1'b0;
`endif

    assign mac_sta       = sta_q;
    assign mac_psum_init = init_q;
    assign out_valid     = out_valid_q;
    assign out_psum      = out_psum_q;
    assign {mac_flg_act, mac_act, mac_flg_wei, mac_wei} = ops_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            init_q      <= '0;
            out_psum_q  <= '0;
            first_q     <= 1'b1;
            last_q      <= 1'b0;
            sta_q       <= 1'b0;
            out_valid_q <= 1'b0;
            ops_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Outputs are registered, so the ISSUE-cycle values are loaded here.
                    if (count != 2'd0 && mac_fnh) begin
                        state_q <= ST_ISSUE;
                        init_q  <= first_q ? '0 : acc_q;
                        if (!skip) begin
                            sta_q <= 1'b1;
                            ops_q <= head[OPS_W-1:0];
                        end
                    end
                end
                ST_ISSUE: begin
                    sta_q  <= 1'b0;
                    ops_q  <= '0;
                    init_q <= '0;
                    last_q <= h_last;
                    if (skip) begin
                        acc_q   <= first_q ? '0 : acc_q;
                        first_q <= 1'b0;
                        if (h_last) begin
                            out_valid_q <= 1'b1;
                            out_psum_q  <= first_q ? '0 : acc_q;
                            state_q     <= ST_EMIT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        state_q <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!mac_fnh) state_q <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (mac_fnh) begin
                        acc_q   <= mac_psum;
                        first_q <= 1'b0;
                        if (last_q) begin
                            out_valid_q <= 1'b1;
                            out_psum_q  <= mac_psum;
                            state_q     <= ST_EMIT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        first_q     <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dispatch.sv
// Self-checking bench for mac_dispatch: behavioural MAC model, block/result
// scoreboards, a table of chained-output cases and hand-written corner sequences.
module tb_mac_dispatch;

    localparam int DW = 8;
    localparam int BD = 32;
    localparam int PW = 23;

`ifdef MAC_DISPATCH_ZSKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [BD-1:0]        in_flg_act;
    logic [DW*BD-1:0]     in_act;
    logic [BD-1:0]        in_flg_wei;
    logic [DW*BD-1:0]     in_wei;
    logic                 in_last;
    logic                 mac_sta;
    logic                 mac_fnh;
    logic [BD-1:0]        mac_flg_act;
    logic [DW*BD-1:0]     mac_act;
    logic [BD-1:0]        mac_flg_wei;
    logic [DW*BD-1:0]     mac_wei;
    logic signed [PW-1:0] mac_psum_init;
    logic signed [PW-1:0] mac_psum;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [PW-1:0] out_psum;

    mac_dispatch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_flg_act(in_flg_act), .in_act(in_act),
        .in_flg_wei(in_flg_wei), .in_wei(in_wei), .in_last(in_last),
        .mac_sta(mac_sta), .mac_fnh(mac_fnh),
        .mac_flg_act(mac_flg_act), .mac_act(mac_act),
        .mac_flg_wei(mac_flg_wei), .mac_wei(mac_wei),
        .mac_psum_init(mac_psum_init), .mac_psum(mac_psum),
        .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int seq;
        bit last;
        bit zero;
    } rec_t;

    rec_t                 rec_q[$];
    logic signed [PW-1:0] out_q[$];

    // MAC model state
    int                   pulses = 0;
    int                   n_out  = 0;
    int                   lat    = 2;
    int                   cnt    = 0;
    bit                   busy   = 1'b0;
    bit                   m_first = 1'b1;
    bit                   cur_last = 1'b0;
    logic signed [PW-1:0] m_acc = '0;
    logic signed [PW-1:0] exp_init = '0;
    logic signed [PW-1:0] delta = 10;
    logic signed [PW-1:0] last_out = '0;
    rec_t                 mr;

    // in_ready model
    bit rdy_chk  = 1'b0;
    bit saw_low  = 1'b0;
    int f_cnt    = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mac_fnh  = 1'b1;
            busy     = 1'b0;
            m_first  = 1'b1;
            m_acc    = '0;
            mac_psum = '0;
        end else if (mac_sta) begin
            pulses++;
            chk("sta_while_mac_busy", busy, 0);
            while (rec_q.size() > 0 && rec_q[0].zero) begin
                mr = rec_q.pop_front();
                if (m_first) m_acc = '0;
                m_first = 1'b0;
                if (mr.last) begin
                    out_q.push_back(m_acc);
                    m_first = 1'b1;
                end
            end
            chk("sta_has_block", rec_q.size() > 0, 1);
            exp_init = m_first ? '0 : m_acc;
            chk("psum_init", mac_psum_init, exp_init);
            cur_last = 1'b0;
            if (rec_q.size() > 0) begin
                mr = rec_q.pop_front();
                chk("seq_id", mac_act[7:0], mr.seq);
                cur_last = mr.last;
            end
            busy     = 1'b1;
            cnt      = lat;
            mac_fnh  = 1'b0;
            mac_psum = PW'($urandom);
        end else if (busy) begin
            if (cnt == 0) begin
                m_acc    = exp_init + delta;
                mac_psum = m_acc;
                mac_fnh  = 1'b1;
                busy     = 1'b0;
                m_first  = 1'b0;
                if (cur_last) begin
                    out_q.push_back(m_acc);
                    m_first = 1'b1;
                end
            end else begin
                cnt--;
                mac_psum = PW'($urandom);
            end
        end else begin
            mac_psum = PW'($urandom);
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            last_out = out_psum;
            chk("out_expected", out_q.size() > 0, 1);
            if (out_q.size() > 0) chk("out_psum", out_psum, out_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rdy_chk) begin
            chk("in_ready", in_ready, f_cnt < 2);
            if (!in_ready) saw_low = 1'b1;
            f_cnt = f_cnt + int'(in_valid && in_ready) - int'(mac_sta);
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input int seq, input bit last, input logic [BD-1:0] fa,
                        input logic [BD-1:0] fw);
        int i;
        in_valid   = 1'b1;
        in_last    = last;
        in_flg_act = fa;
        in_flg_wei = fw;
        in_act     = '0;
        in_act[7:0] = seq[7:0];
        in_wei     = {BD{seq[7:0]}};
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("accept_timeout", i < 200, 1);
        if (i < 200) begin
            rec_q.push_back('{seq, last, ZSKIP && ((fa & fw) == '0)});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rec_q.size() == 0 && out_q.size() == 0 && !busy && !out_valid) break;
        end
        chk("drain_timeout", i < budget, 1);
    endtask

    typedef struct {
        int                   nblk;
        int                   lat;
        logic signed [PW-1:0] delta;
        logic signed [PW-1:0] exp_out;
    } tcase_t;

    tcase_t tbl[5];
    int     seq = 1;
    int     p0, o0;

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{3, 2, 23'sd10, 23'sd30};
        tbl[1] = '{1, 1, 23'sd10, 23'sd10};
        tbl[2] = '{5, 3, 23'sd7,  23'sd35};
        tbl[3] = '{2, 1, 23'sh3FFFFF, -23'sd2};
        tbl[4] = '{4, 1, -23'sd5, -23'sd20};

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_flg_act = '0; in_flg_wei = '0; in_act = '0; in_wei = '0;
        out_ready = 1'b1; mac_fnh = 1'b1; mac_psum = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mac_sta", mac_sta, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_psum", out_psum, 0);
        chk("rst_psum_init", mac_psum_init, 0);
        chk("rst_mac_ops", ((mac_act | mac_wei) == '0) && (mac_flg_act == '0) && (mac_flg_wei == '0), 1);
        sync();
        rst_n = 1'b1;

        // chained outputs: pulses and final sum per case
        for (int t = 0; t < 5; t++) begin
            p0 = pulses; o0 = n_out;
            lat = tbl[t].lat; delta = tbl[t].delta;
            sync();
            for (int b = 0; b < tbl[t].nblk; b++) begin
                send(seq, b == tbl[t].nblk - 1, '1, '1);
                seq++;
            end
            in_valid = 1'b0;
            wait_done(3000);
            chk("tbl_pulses", pulses - p0, tbl[t].nblk);
            chk("tbl_outputs", n_out - o0, 1);
            chk("tbl_out_psum", last_out, tbl[t].exp_out);
        end

        // MAC holds mac_fnh low for a long time
        lat = 20; delta = 10; p0 = pulses;
        sync();
        send(seq, 1'b0, '1, '1); seq++;
        send(seq, 1'b1, '1, '1); seq++;
        in_valid = 1'b0;
        for (int i = 0; i < 100 && pulses < p0 + 1; i++) @(negedge clk);
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            chk("hold_no_second_sta", pulses - p0, 1);
        end
        wait_done(3000);
        chk("hold_pulses", pulses - p0, 2);
        chk("hold_out_psum", last_out, 20);

        // in_valid held high with a slow MAC: exact in_ready tracking
        lat = 8; p0 = pulses;
        f_cnt = 0; saw_low = 1'b0; rdy_chk = 1'b1;
        sync();
        for (int b = 0; b < 5; b++) begin
            send(seq, b == 4, '1, '1);
            seq++;
        end
        in_valid = 1'b0;
        wait_done(3000);
        rdy_chk = 1'b0;
        chk("bp_saw_ready_low", saw_low, 1);
        chk("bp_pulses", pulses - p0, 5);
        chk("bp_out_psum", last_out, 50);

        // consumer stalls in EMIT
        lat = 2; out_ready = 1'b0;
        sync();
        send(seq, 1'b1, '1, '1); seq++;
        in_valid = 1'b0;
        for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_psum", out_psum, 10);
        end
        out_ready = 1'b1;
        wait_done(1000);
        sync();
        send(seq, 1'b1, '1, '1); seq++;
        in_valid = 1'b0;
        wait_done(1000);
        chk("post_stall_out", last_out, 10);

        // zero-flag block in the middle of an output
        p0 = pulses;
        sync();
        send(seq, 1'b0, '1, '1); seq++;
        send(seq, 1'b0, 32'h0000_FFFF, 32'hFFFF_0000); seq++;
        send(seq, 1'b1, '1, '1); seq++;
        in_valid = 1'b0;
        wait_done(2000);
        chk("zskip_pulses", pulses - p0, ZSKIP ? 2 : 3);
        chk("zskip_out_psum", last_out, ZSKIP ? 20 : 30);

        // reset while waiting on the MAC with two blocks buffered
        lat = 30; p0 = pulses;
        sync();
        send(seq, 1'b0, '1, '1); seq++;
        send(seq, 1'b0, '1, '1); seq++;
        send(seq, 1'b1, '1, '1); seq++;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_rst_in_wait", busy && (pulses - p0 == 1), 1);
        sync();
        rst_n = 1'b0;
        rec_q.delete();
        out_q.delete();
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_mac_sta", mac_sta, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_psum", out_psum, 0);
        chk("mid_rst_psum_init", mac_psum_init, 0);
        chk("mid_rst_mac_ops", ((mac_act | mac_wei) == '0) && (mac_flg_act == '0) && (mac_flg_wei == '0), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lat = 2; p0 = pulses;
        repeat (10) @(negedge clk);
        chk("post_rst_no_sta", pulses - p0, 0);
        sync();
        send(seq, 1'b1, '1, '1); seq++;
        in_valid = 1'b0;
        wait_done(1000);
        chk("post_rst_pulses", pulses - p0, 1);
        chk("post_rst_out_psum", last_out, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
